// File: rtl/csr_hpm_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_hpm_counter_bank_if
// Description : CSR access channel between the CSR unit (master) and the
//               hardware performance counter bank (slave). One-cycle request
//               strobe with address/op/data, registered response one cycle
//               later.
//               Signals:
//                 csr_req    master->slave  access strobe
//                 csr_addr   master->slave  12-bit CSR address
//                 csr_op     master->slave  00 read, 01 write, 10 set, 11 clear
//                 csr_wdata  master->slave  write data / set-clear mask
//                 csr_rvalid slave->master  response valid
//                 csr_hit    slave->master  address mapped to this bank
//                 csr_rdata  slave->master  pre-access CSR value
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_hpm_counter_bank_if;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_rvalid;
    logic        csr_hit;
    logic [31:0] csr_rdata;

    modport master (
        output csr_req, csr_addr, csr_op, csr_wdata,
        input  csr_rvalid, csr_hit, csr_rdata
    );

    modport slave (
        input  csr_req, csr_addr, csr_op, csr_wdata,
        output csr_rvalid, csr_hit, csr_rdata
    );
endinterface
`default_nettype wire

// File: rtl/csr_hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : csr_hpm_counter_bank
// Description : Bank of RV32 machine hardware performance counters
//               (mhpmcounter3+/mhpmcounterh3+, mhpmevent3+, mcountinhibit).
//               Each counter increments on the core event chosen by its
//               mhpmevent select field unless inhibited. CSR accesses arrive
//               over csr_hpm_counter_bank_if and are answered one cycle later
//               with the value held before the access.
//               Optional feature macro: CSR_HPM_OVERFLOW_IRQ_EN
//                 defined     : mhpmevent[31]=OF (sticky wrap flag),
//                               mhpmevent[30]=OFIE, hpm_irq = OR(OF & OFIE)
//                 not defined : mhpmevent[31:30] read 0, hpm_irq tied 0
//               Ports:
//                 clk      core clock
//                 rst      synchronous active-high reset
//                 events   one-cycle event pulses from the core
//                 bus      CSR access channel (slave side)
//                 hpm_irq  counter-overflow interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module csr_hpm_counter_bank #(
    parameter int NUM_COUNTERS = 4,
    parameter int COUNTER_W    = 64,
    parameter int NUM_EVENTS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_EVENTS-1:0]   events,
    csr_hpm_counter_bank_if.slave   bus,
    output logic                    hpm_irq
);

    localparam int EVSEL_W = $clog2(NUM_EVENTS + 1);
    // Event vector padded so every select code indexes a real bit; code 0
    // maps to a constant-zero slot, codes above NUM_EVENTS never get stored.
    localparam int c_ev_pad = 1 << EVSEL_W;
    localparam int c_hi_w   = COUNTER_W - 32;

    localparam logic [11:0] c_addr_inhibit = 12'h320;
    localparam logic [11:0] c_addr_event   = 12'h323;
    localparam logic [11:0] c_addr_cnt_lo  = 12'hB03;
    localparam logic [11:0] c_addr_cnt_hi  = 12'hB83;

    localparam logic [1:0] c_op_read  = 2'b00;
    localparam logic [1:0] c_op_write = 2'b01;
    localparam logic [1:0] c_op_set   = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COUNTER_W-1:0]    r_cnt [NUM_COUNTERS];
    logic [EVSEL_W-1:0]      r_sel [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] r_inh;

    logic                    r_rvalid;
    logic                    r_hit;
    logic [31:0]             r_rdata;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                    w_inh_hit;
    logic [NUM_COUNTERS-1:0] w_lo_hit;
    logic [NUM_COUNTERS-1:0] w_hi_hit;
    logic [NUM_COUNTERS-1:0] w_ev_hit;
    logic                    w_hit;
    logic                    w_wr;
    logic [31:0]             w_old;
    logic [31:0]             w_new;
    logic [EVSEL_W-1:0]      w_sel_legal;
    logic [c_ev_pad-1:0]     w_evt_pad;
    logic [NUM_COUNTERS-1:0] w_inc;
    logic [NUM_COUNTERS-1:0] w_cnt_wr;
    logic [NUM_COUNTERS-1:0] w_of_rd;
    logic [NUM_COUNTERS-1:0] w_ofie_rd;

    // Address decode
    always_comb begin
        w_inh_hit = (bus.csr_addr == c_addr_inhibit);
        w_lo_hit  = '0;
        w_hi_hit  = '0;
        w_ev_hit  = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            w_lo_hit[i] = (bus.csr_addr == 12'(c_addr_cnt_lo + 12'(i)));
            w_hi_hit[i] = (bus.csr_addr == 12'(c_addr_cnt_hi + 12'(i)));
            w_ev_hit[i] = (bus.csr_addr == 12'(c_addr_event  + 12'(i)));
        end
    end

    assign w_hit = w_inh_hit | (|w_lo_hit) | (|w_hi_hit) | (|w_ev_hit);
    assign w_wr  = bus.csr_req & (bus.csr_op != c_op_read) & w_hit;

    // Pre-access read value; unmapped addresses fall through to zero
    always_comb begin
        w_old = '0;
        if (w_inh_hit) begin
            w_old[3 +: NUM_COUNTERS] = r_inh;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_lo_hit[i]) begin
                w_old = r_cnt[i][31:0];
            end
            if (w_hi_hit[i]) begin
                w_old[c_hi_w-1:0] = r_cnt[i][COUNTER_W-1:32];
            end
            if (w_ev_hit[i]) begin
                w_old[EVSEL_W-1:0] = r_sel[i];
                w_old[31]          = w_of_rd[i];
                w_old[30]          = w_ofie_rd[i];
            end
        end
    end

    always_comb begin
        case (bus.csr_op)
            c_op_write: w_new = bus.csr_wdata;
            c_op_set:   w_new = w_old | bus.csr_wdata;
            default:    w_new = w_old & ~bus.csr_wdata;
        endcase
    end

    // WARL select: unsupported event codes collapse to "no event"
    assign w_sel_legal = (w_new[EVSEL_W-1:0] > EVSEL_W'(NUM_EVENTS)) ? '0
                                                                      : w_new[EVSEL_W-1:0];

    always_comb begin
        w_evt_pad                 = '0;
        w_evt_pad[NUM_EVENTS:1]   = events;
    end

    always_comb begin
        w_inc    = '0;
        w_cnt_wr = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            w_inc[i]    = (r_sel[i] != '0) && w_evt_pad[r_sel[i]] && !r_inh[i];
            w_cnt_wr[i] = w_wr && (w_lo_hit[i] || w_hi_hit[i]);
        end
    end

    // ------------------------------------------------------------------
    // Counter, select and inhibit state. A CSR write to either half of a
    // counter takes priority and drops that cycle's increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cnt[i] <= '0;
                r_sel[i] <= '0;
            end
            r_inh <= '1;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (w_wr && w_lo_hit[i]) begin
                    r_cnt[i][31:0] <= w_new;
                end else if (w_wr && w_hi_hit[i]) begin
                    r_cnt[i][COUNTER_W-1:32] <= w_new[c_hi_w-1:0];
                end else if (w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] + COUNTER_W'(1);
                end
                if (w_wr && w_ev_hit[i]) begin
                    r_sel[i] <= w_sel_legal;
                end
            end
            if (w_wr && w_inh_hit) begin
                r_inh <= w_new[3 +: NUM_COUNTERS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_hit    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.csr_req;
            r_hit    <= bus.csr_req & w_hit;
            r_rdata  <= bus.csr_req ? w_old : '0;
        end
    end

    assign bus.csr_rvalid = r_rvalid;
    assign bus.csr_hit    = r_hit;
    assign bus.csr_rdata  = r_rdata;

    // ------------------------------------------------------------------
    // Overflow flags and interrupt
    // ------------------------------------------------------------------
`ifdef CSR_HPM_OVERFLOW_IRQ_EN
    logic [NUM_COUNTERS-1:0] r_of;
    logic [NUM_COUNTERS-1:0] r_ofie;
    logic                    r_irq;
    logic [NUM_COUNTERS-1:0] w_of_nxt;
    logic [NUM_COUNTERS-1:0] w_ofie_nxt;

    // The wrap is applied after the CSR write so a same-cycle wrap keeps OF
    // set even when software writes bit 31 to 0.
    always_comb begin
        w_of_nxt   = r_of;
        w_ofie_nxt = r_ofie;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_wr && w_ev_hit[i]) begin
                w_of_nxt[i]   = w_new[31];
                w_ofie_nxt[i] = w_new[30];
            end
            if (w_inc[i] && !w_cnt_wr[i] && (&r_cnt[i])) begin
                w_of_nxt[i] = 1'b1;
            end
        end
    end

    // Interrupt is registered from the next-state flags so it always tracks
    // the architecturally visible OF/OFIE bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_of   <= '0;
            r_ofie <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_of   <= w_of_nxt;
            r_ofie <= w_ofie_nxt;
            r_irq  <= |(w_of_nxt & w_ofie_nxt);
        end
    end

    assign w_of_rd   = r_of;
    assign w_ofie_rd = r_ofie;
    assign hpm_irq   = r_irq;
`else
    assign w_of_rd   = '0;
    assign w_ofie_rd = '0;
    assign hpm_irq   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_hpm_counter_bank
// Description : Scoreboard bench for csr_hpm_counter_bank. A driver applies
//               directed and random CSR accesses and event pulses, a
//               behavioural model predicts each cycle's response and
//               interrupt level into a queue, and a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_hpm_counter_bank;

    localparam int N  = 4;
    localparam int CW = 64;
    localparam int NE = 16;
    localparam int SW = $clog2(NE + 1);
    localparam longint unsigned CMAX = {64{1'b1}} >> (64 - CW);

`ifdef CSR_HPM_OVERFLOW_IRQ_EN
    localparam logic [31:0] EV3_WR   = 32'h4000_0001;
    localparam logic [31:0] EV3_OF   = 32'hC000_0001;
    localparam logic [31:0] EV3_CLR  = 32'h4000_0001;
`else
    localparam logic [31:0] EV3_WR   = 32'h0000_0001;
    localparam logic [31:0] EV3_OF   = 32'h0000_0001;
    localparam logic [31:0] EV3_CLR  = 32'h0000_0001;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NE-1:0] events = '0;
    logic          hpm_irq;

    csr_hpm_counter_bank_if bus ();

    csr_hpm_counter_bank #(
        .NUM_COUNTERS (N),
        .COUNTER_W    (CW),
        .NUM_EVENTS   (NE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .events  (events),
        .bus     (bus),
        .hpm_irq (hpm_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          hit;
        logic [31:0] rd;
        bit          irq;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    longint unsigned m_cnt  [N];
    int              m_sel  [N];
    bit              m_inh  [N];
    bit              m_of   [N];
    bit              m_ofie [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_sel[i]  = 0;
            m_inh[i]  = 1'b1;
            m_of[i]   = 1'b0;
            m_ofie[i] = 1'b0;
        end
    endtask

    task automatic m_read(input logic [11:0] a, output bit hit, output logic [31:0] v);
        hit = 1'b0;
        v   = '0;
        if (a == 12'h320) begin
            hit = 1'b1;
            for (int i = 0; i < N; i++) v[3+i] = m_inh[i];
        end
        for (int i = 0; i < N; i++) begin
            if (a == 12'(12'hB03 + i)) begin hit = 1'b1; v = m_cnt[i][31:0]; end
            if (a == 12'(12'hB83 + i)) begin hit = 1'b1; v = 32'(m_cnt[i] >> 32); end
            if (a == 12'(12'h323 + i)) begin
                hit = 1'b1;
                v   = 32'(m_sel[i]);
`ifdef CSR_HPM_OVERFLOW_IRQ_EN
                v[31] = m_of[i];
                v[30] = m_ofie[i];
`endif
            end
        end
    endtask

    // Predict one cycle: response from pre-access state, then apply the
    // access and the event counting for this cycle.
    task automatic model(input bit req, input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] wd, input logic [NE-1:0] ev, input bit rst_v,
                         input bit use_want, input logic [31:0] want);
        exp_t        e;
        bit          hit;
        logic [31:0] old;
        logic [31:0] nv;
        bit          inc [N];
        bit          written [N];
        int          s;
        if (rst_v) begin
            m_reset();
            e.v = 1'b0; e.hit = 1'b0; e.rd = '0; e.irq = 1'b0;
            q.push_back(e);
            return;
        end
        m_read(a, hit, old);
        e.v   = req;
        e.hit = req && hit;
        e.rd  = use_want ? want : old;
        for (int i = 0; i < N; i++) begin
            inc[i]     = (m_sel[i] != 0) && ev[m_sel[i]-1] && !m_inh[i];
            written[i] = 1'b0;
        end
        if (req && hit && op != 2'b00) begin
            case (op)
                2'b01:   nv = wd;
                2'b10:   nv = old | wd;
                default: nv = old & ~wd;
            endcase
            if (a == 12'h320) for (int i = 0; i < N; i++) m_inh[i] = nv[3+i];
            for (int i = 0; i < N; i++) begin
                if (a == 12'(12'hB03 + i)) begin
                    m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | {32'h0, nv};
                    written[i] = 1'b1;
                end
                if (a == 12'(12'hB83 + i)) begin
                    m_cnt[i] = ((m_cnt[i] & 64'hFFFF_FFFF) | ({32'h0, nv} << 32)) & CMAX;
                    written[i] = 1'b1;
                end
                if (a == 12'(12'h323 + i)) begin
                    s = int'(nv) & ((1 << SW) - 1);
                    m_sel[i]  = (s > NE) ? 0 : s;
                    m_of[i]   = nv[31];
                    m_ofie[i] = nv[30];
                end
            end
        end
        e.irq = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (inc[i] && !written[i]) begin
                if (m_cnt[i] == CMAX) begin
                    m_cnt[i] = 0;
                    m_of[i]  = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
`ifdef CSR_HPM_OVERFLOW_IRQ_EN
            if (m_of[i] && m_ofie[i]) e.irq = 1'b1;
`endif
        end
        q.push_back(e);
    endtask

    task automatic step(input bit req, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic [NE-1:0] ev,
                        input bit rst_v = 1'b0, input bit use_want = 1'b0,
                        input logic [31:0] want = '0);
        @(negedge clk);
        rst           = rst_v;
        bus.csr_req   = req;
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
        events        = ev;
        model(req, a, op, wd, ev, rst_v, use_want, want);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] want);
        step(1'b1, a, 2'b00, 32'h0, '0, 1'b0, 1'b1, want);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                      input logic [NE-1:0] ev);
        step(1'b1, a, op, wd, ev);
    endtask

    task automatic idle(input logic [NE-1:0] ev);
        step(1'b0, 12'h000, 2'b00, 32'h0, ev);
    endtask

    // Monitor: one prediction per driven cycle, checked after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rvalid", 32'(bus.csr_rvalid), 32'(e.v));
                if (e.v) begin
                    chk("hit", 32'(bus.csr_hit), 32'(e.hit));
                    chk("rdata", bus.csr_rdata, e.rd);
                end
                chk("hpm_irq", 32'(hpm_irq), 32'(e.irq));
            end
        end
    end

    initial begin
        logic [11:0] a;
        logic [31:0] wd;
        int          k;
        int          idx;
        m_reset();
        bus.csr_req   = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_op    = '0;
        bus.csr_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rvalid", 32'(bus.csr_rvalid), 32'h0);
        chk("reset_hit",    32'(bus.csr_hit),    32'h0);
        chk("reset_rdata",  bus.csr_rdata,       32'h0);
        chk("reset_irq",    32'(hpm_irq),        32'h0);

        // Reset values
        rd(12'h320, 32'h0000_0078);
        rd(12'hB03, 32'h0);

        // Count event 2 (events[1]) with events[0] noise
        wr(12'h323, 2'b01, 32'h2, '0);
        wr(12'h320, 2'b11, 32'h8, '0);
        repeat (5) idle(16'h0003);
        rd(12'hB03, 32'h5);

        // WARL select: 17 is out of range, counter 4 never counts
        wr(12'h324, 2'b01, 32'd17, '0);
        rd(12'h324, 32'h0);
        wr(12'h320, 2'b11, 32'h10, '0);
        repeat (3) idle('1);
        rd(12'hB04, 32'h0);

        // Full-width wrap
        wr(12'h323, 2'b01, EV3_WR, '0);
        wr(12'hB03, 2'b01, 32'hFFFF_FFFF, '0);
        wr(12'hB83, 2'b01, 32'hFFFF_FFFF, '0);
        idle(16'h0001);
        rd(12'hB03, 32'h0);
        rd(12'hB83, 32'h0);
        rd(12'h323, EV3_OF);
        wr(12'h323, 2'b11, 32'h8000_0000, '0);
        idle('0);
        rd(12'h323, EV3_CLR);

        // Write wins over a same-cycle increment
        wr(12'hB03, 2'b01, 32'h10, 16'h0001);
        rd(12'hB03, 32'h10);
        idle(16'h0001);
        rd(12'hB03, 32'h11);

        // Set on inhibit returns prior value, then unmapped read back to back
        step(1'b1, 12'h320, 2'b10, 32'h8, '0, 1'b0, 1'b1, 32'h0000_0060);
        rd(12'h7FF, 32'h0);

        // Reset with an access in flight drops the response
        step(1'b1, 12'h323, 2'b01, 32'h5, '1, 1'b1);
        idle('0);
        rd(12'h320, 32'h0000_0078);

        // Random phase
        for (int n = 0; n < 600; n++) begin
            k   = $urandom_range(0, 9);
            idx = $urandom_range(0, N - 1);
            case (k)
                0:       a = 12'h320;
                1, 2, 8: a = 12'(12'hB03 + idx);
                3, 4, 9: a = 12'(12'hB83 + idx);
                5, 6:    a = 12'(12'h323 + idx);
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = 12'h7FF;
                        1:       a = 12'(12'hB03 + N);
                        2:       a = 12'h321;
                        default: a = 12'h300;
                    endcase
                end
            endcase
            case ($urandom_range(0, 3))
                0:       wd = 32'hFFFF_FFFF;
                1:       wd = 32'hFFFF_FFFE;
                2:       wd = $urandom_range(0, 63);
                default: wd = $urandom;
            endcase
            // Keep counters mostly enabled so counting and wraps occur
            if (a == 12'h320 && $urandom_range(0, 1) == 0) wd = 32'h0;
            step(($urandom_range(0, 3) != 0), a, 2'($urandom_range(0, 3)), wd,
                 NE'($urandom));
        end

        idle('0);
        idle('0);
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
